mem_ctrl_rr: RTL and testbench

Parametrised multi-channel memory controller. Arbitrates NUM_CH system requestors onto one single-port synchronous memory core using round-robin arbitration. It is the successor to the single-channel sys/mem controller: width, depth and channel count are generalised, and memory read latency is configurable. The shared bidirectional data bus is replaced by separate write-data and read-data paths with a per-channel read-valid pulse.

---
 rtl/mem_ctrl_rr.sv | 166 ++++++++++++++++
 tb/tb_mem_ctrl_rr.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_rr.sv
// Round-robin arbiter placing NUM_CH requestors onto one single-port synchronous memory.
// One command is in flight at a time; read data returns RD_LAT cycles after the ce_mem cycle.
module mem_ctrl_rr #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int NUM_CH = 2,
   parameter int RD_LAT = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          cmd_valid_sys,
   input  logic [NUM_CH-1:0]          we_sys,
   input  logic [NUM_CH*ADDR_W-1:0]   addr_sys,
   input  logic [NUM_CH*DATA_W-1:0]   wdata_sys,
   output logic [NUM_CH-1:0]          ready_sys,
   output logic [DATA_W-1:0]          rdata_sys,
   output logic [NUM_CH-1:0]          rvalid_sys,
   output logic                       we_mem,
   output logic                       ce_mem,
   output logic [ADDR_W-1:0]          addr_mem,
   output logic [DATA_W-1:0]          datai_mem,
   input  logic [DATA_W-1:0]          datao_mem
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int LAT_W = 3;

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("mem_ctrl_rr: RD_LAT must be within 1..4");
   end
   if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
      $error("mem_ctrl_rr: NUM_CH must be within 2..8");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} state_t;

   state_t             state_q, state_d;
   logic [CH_W-1:0]    rr_q, rr_d;
   logic [CH_W-1:0]    g_q, g_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic [NUM_CH-1:0]  ready_q, ready_d;
   logic [NUM_CH-1:0]  rvalid_q, rvalid_d;
   logic               ce_q, ce_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  datai_q, datai_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;

   logic [ADDR_W-1:0]  addr_ch  [NUM_CH];
   logic [DATA_W-1:0]  wdata_ch [NUM_CH];

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
      assign addr_ch[gi]  = addr_sys[gi*ADDR_W +: ADDR_W];
      assign wdata_ch[gi] = wdata_sys[gi*DATA_W +: DATA_W];
   end

   // Scan from the highest offset down so the nearest requestor above rr_q wins.
   logic [CH_W-1:0] grant;
   logic            any_req;
   always_comb begin
      int              idx;
      logic [CH_W-1:0] sel;
      grant   = rr_q;
      any_req = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         sel = CH_W'(idx);
         if (cmd_valid_sys[sel]) begin
            grant   = sel;
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      g_d      = g_q;
      lat_d    = lat_q;
      ready_d  = '0;
      rvalid_d = '0;
      ce_d     = 1'b0;
      we_d     = 1'b0;
      addr_d   = '0;
      datai_d  = '0;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               g_d            = grant;
               rr_d           = (int'(grant) == NUM_CH - 1) ? '0 : grant + CH_W'(1);
               state_d        = ISSUE;
               ce_d           = 1'b1;
               we_d           = we_sys[grant];
               addr_d         = addr_ch[grant];
               datai_d        = we_sys[grant] ? wdata_ch[grant] : '0;
               ready_d[grant] = 1'b1;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = IDLE;
            end else begin
               state_d = RWAIT;
               lat_d   = '0;
            end
         end
         RWAIT: begin
            // datao_mem is valid in the last wait cycle; capture it on the way to RESP.
            if (lat_q == LAT_W'(RD_LAT - 1)) begin
               rdata_d       = datao_mem;
               rvalid_d[g_q] = 1'b1;
               state_d       = RESP;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_q     <= '0;
         g_q      <= '0;
         lat_q    <= '0;
         ready_q  <= '0;
         rvalid_q <= '0;
         ce_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         datai_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         g_q      <= g_d;
         lat_q    <= lat_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         ce_q     <= ce_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         datai_q  <= datai_d;
         rdata_q  <= rdata_d;
      end
   end

   assign ready_sys  = ready_q;
   assign rvalid_sys = rvalid_q;
   assign rdata_sys  = rdata_q;
   assign ce_mem     = ce_q;
   assign we_mem     = we_q;
   assign addr_mem   = addr_q;
   assign datai_mem  = datai_q;

endmodule

// File: tb/tb_mem_ctrl_rr.sv
// Directed bench for mem_ctrl_rr: three instances cover 2ch/RD_LAT=1, 4ch/RD_LAT=3 and a wide 2ch/RD_LAT=2 build.
module tb_mem_ctrl_rr;

   logic clk;
   int   total;
   int   bad;
   logic [127:0] obs;
   logic [127:0] exp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: NUM_CH=2, 8/8, RD_LAT=1
   logic        rst_a;
   logic [1:0]  cmd_a, we_a, ready_a, rvalid_a;
   logic [15:0] addr_a, wdata_a;
   logic [7:0]  rdata_a, addrm_a, datai_a, datao_a;
   logic        wem_a, cem_a;
   logic [7:0]  mem_a [256];

   mem_ctrl_rr #(.ADDR_W(8), .DATA_W(8), .NUM_CH(2), .RD_LAT(1)) dut_a (
      .clk(clk), .reset(rst_a), .cmd_valid_sys(cmd_a), .we_sys(we_a),
      .addr_sys(addr_a), .wdata_sys(wdata_a), .ready_sys(ready_a),
      .rdata_sys(rdata_a), .rvalid_sys(rvalid_a), .we_mem(wem_a), .ce_mem(cem_a),
      .addr_mem(addrm_a), .datai_mem(datai_a), .datao_mem(datao_a)
   );

   always @(posedge clk) begin
      if (cem_a && wem_a) mem_a[addrm_a] <= datai_a;
      if (cem_a && !wem_a) datao_a <= mem_a[addrm_a];
   end

   // Instance B: NUM_CH=4, 8/8, RD_LAT=3
   logic        rst_b;
   logic [3:0]  cmd_b, we_b, ready_b, rvalid_b;
   logic [31:0] addr_b, wdata_b;
   logic [7:0]  rdata_b, addrm_b, datai_b, datao_b, pipe_b0, pipe_b1;
   logic        wem_b, cem_b;
   logic [7:0]  mem_b [256];

   mem_ctrl_rr #(.ADDR_W(8), .DATA_W(8), .NUM_CH(4), .RD_LAT(3)) dut_b (
      .clk(clk), .reset(rst_b), .cmd_valid_sys(cmd_b), .we_sys(we_b),
      .addr_sys(addr_b), .wdata_sys(wdata_b), .ready_sys(ready_b),
      .rdata_sys(rdata_b), .rvalid_sys(rvalid_b), .we_mem(wem_b), .ce_mem(cem_b),
      .addr_mem(addrm_b), .datai_mem(datai_b), .datao_mem(datao_b)
   );

   always @(posedge clk) begin
      if (cem_b && wem_b) mem_b[addrm_b] <= datai_b;
      if (cem_b && !wem_b) pipe_b0 <= mem_b[addrm_b];
      pipe_b1 <= pipe_b0;
      datao_b <= pipe_b1;
   end

   // Instance C: NUM_CH=2, ADDR_W=10, DATA_W=32, RD_LAT=2
   logic        rst_c;
   logic [1:0]  cmd_c, we_c, ready_c, rvalid_c;
   logic [19:0] addr_c;
   logic [63:0] wdata_c;
   logic [31:0] rdata_c, datai_c, datao_c, pipe_c;
   logic [9:0]  addrm_c;
   logic        wem_c, cem_c;
   logic [31:0] mem_c [1024];

   mem_ctrl_rr #(.ADDR_W(10), .DATA_W(32), .NUM_CH(2), .RD_LAT(2)) dut_c (
      .clk(clk), .reset(rst_c), .cmd_valid_sys(cmd_c), .we_sys(we_c),
      .addr_sys(addr_c), .wdata_sys(wdata_c), .ready_sys(ready_c),
      .rdata_sys(rdata_c), .rvalid_sys(rvalid_c), .we_mem(wem_c), .ce_mem(cem_c),
      .addr_mem(addrm_c), .datai_mem(datai_c), .datao_mem(datao_c)
   );

   always @(posedge clk) begin
      if (cem_c && wem_c) mem_c[addrm_c] <= datai_c;
      if (cem_c && !wem_c) pipe_c <= mem_c[addrm_c];
      datao_c <= pipe_c;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      cmd_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
      cmd_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
      cmd_c = '0; we_c = '0; addr_c = '0; wdata_c = '0;
      tick();
      tick();
      obs = 128'({ready_a, rvalid_a, rdata_a, wem_a, cem_a, addrm_a, datai_a}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL reset_a got=%0h exp=%0h", obs, exp); end
      obs = 128'({ready_b, rvalid_b, rdata_b, wem_b, cem_b, addrm_b, datai_b}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL reset_b got=%0h exp=%0h", obs, exp); end
      obs = 128'({ready_c, rvalid_c, rdata_c, wem_c, cem_c, addrm_c, datai_c}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL reset_c got=%0h exp=%0h", obs, exp); end
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      tick();
      obs = 128'({ready_a, rvalid_a, cem_a, ready_b, rvalid_b, cem_b, ready_c, rvalid_c, cem_c}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL idle_after_release got=%0h exp=%0h", obs, exp); end
      $display("txn reset done");
   endtask

   task automatic test_write();
      cmd_a = 2'b01; we_a = 2'b01; addr_a = {8'h00, 8'h12}; wdata_a = {8'h00, 8'hA5};
      tick();
      obs = 128'({ready_a, cem_a, wem_a, addrm_a, datai_a});
      exp = 128'({2'b01, 1'b1, 1'b1, 8'h12, 8'hA5});
      total++; if (obs !== exp) begin bad++; $display("FAIL wr_issue got=%0h exp=%0h", obs, exp); end
      cmd_a = '0; we_a = '0;
      tick();
      obs = 128'({ready_a, cem_a, wem_a, addrm_a, datai_a}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL wr_idle got=%0h exp=%0h", obs, exp); end
      $display("txn A ch0 write 0x12=0xa5");
   endtask

   task automatic test_read_lat1();
      cmd_a = 2'b10; we_a = 2'b00; addr_a = {8'h12, 8'h00};
      tick();
      obs = 128'({ready_a, cem_a, wem_a, addrm_a, datai_a, rvalid_a});
      exp = 128'({2'b10, 1'b1, 1'b0, 8'h12, 8'h00, 2'b00});
      total++; if (obs !== exp) begin bad++; $display("FAIL rd1_issue got=%0h exp=%0h", obs, exp); end
      cmd_a = '0;
      tick();
      obs = 128'({rvalid_a, cem_a, ready_a}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL rd1_wait got=%0h exp=%0h", obs, exp); end
      tick();
      obs = 128'({rvalid_a, rdata_a, cem_a}); exp = 128'({2'b10, 8'hA5, 1'b0});
      total++; if (obs !== exp) begin bad++; $display("FAIL rd1_resp got=%0h exp=%0h", obs, exp); end
      tick();
      obs = 128'({rvalid_a, rdata_a}); exp = 128'({2'b00, 8'hA5});
      total++; if (obs !== exp) begin bad++; $display("FAIL rd1_hold got=%0h exp=%0h", obs, exp); end
      $display("txn A ch1 read 0x12 lat1");
   endtask

   task automatic test_back_to_back();
      cmd_a = 2'b01; we_a = 2'b00; addr_a = {8'h00, 8'h12};
      tick();
      obs = 128'({ready_a, cem_a, wem_a, addrm_a}); exp = 128'({2'b01, 1'b1, 1'b0, 8'h12});
      total++; if (obs !== exp) begin bad++; $display("FAIL b2b_rd_issue got=%0h exp=%0h", obs, exp); end
      cmd_a = '0;
      tick();
      tick();
      obs = 128'({rvalid_a, rdata_a, cem_a}); exp = 128'({2'b01, 8'hA5, 1'b0});
      total++; if (obs !== exp) begin bad++; $display("FAIL b2b_resp got=%0h exp=%0h", obs, exp); end
      cmd_a = 2'b10; we_a = 2'b10; addr_a = {8'h34, 8'h00}; wdata_a = {8'h5C, 8'h00};
      tick();
      obs = 128'({ready_a, cem_a, rvalid_a}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL b2b_no_early got=%0h exp=%0h", obs, exp); end
      tick();
      obs = 128'({ready_a, cem_a, wem_a, addrm_a, datai_a, rvalid_a});
      exp = 128'({2'b10, 1'b1, 1'b1, 8'h34, 8'h5C, 2'b00});
      total++; if (obs !== exp) begin bad++; $display("FAIL b2b_wr_issue got=%0h exp=%0h", obs, exp); end
      cmd_a = '0; we_a = '0;
      tick();
      $display("txn A ch0 read then ch1 write");
   endtask

   task automatic test_drop();
      cmd_a = 2'b01; we_a = 2'b11; addr_a = {8'h51, 8'h50}; wdata_a = {8'h22, 8'h11};
      tick();
      obs = 128'({ready_a, addrm_a, datai_a}); exp = 128'({2'b01, 8'h50, 8'h11});
      total++; if (obs !== exp) begin bad++; $display("FAIL drop_issue got=%0h exp=%0h", obs, exp); end
      cmd_a = 2'b10;
      tick();
      cmd_a = 2'b00;
      tick();
      obs = 128'({ready_a, cem_a}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL drop_ignored1 got=%0h exp=%0h", obs, exp); end
      tick();
      obs = 128'({ready_a, cem_a}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL drop_ignored2 got=%0h exp=%0h", obs, exp); end
      we_a = '0;
      $display("txn A ch1 dropped request");
   endtask

   task automatic test_single_repeat();
      cmd_a = 2'b01; we_a = 2'b01; addr_a = {8'h00, 8'h60}; wdata_a = {8'h00, 8'h33};
      for (int k = 1; k <= 6; k++) begin
         tick();
         obs = 128'({ready_a, cem_a});
         exp = (k % 2 == 1) ? 128'({2'b01, 1'b1}) : 128'(0);
         total++; if (obs !== exp) begin bad++; $display("FAIL single_rep k=%0d got=%0h exp=%0h", k, obs, exp); end
      end
      cmd_a = '0; we_a = '0;
      tick();
      $display("txn A ch0 repeated writes");
   endtask

   task automatic test_rotation();
      cmd_b = 4'hF; we_b = 4'hF;
      addr_b = {8'h03, 8'h02, 8'h01, 8'h00}; wdata_b = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
      for (int i = 0; i < 4; i++) begin
         tick();
         obs = 128'({ready_b, cem_b, wem_b, addrm_b, datai_b});
         exp = 128'({4'(1 << i), 1'b1, 1'b1, 8'(i), 8'(8'hC0 + i)});
         total++; if (obs !== exp) begin bad++; $display("FAIL rot_grant%0d got=%0h exp=%0h", i, obs, exp); end
         cmd_b = cmd_b & ~(4'(1) << i);
         tick();
         obs = 128'({ready_b, cem_b}); exp = '0;
         total++; if (obs !== exp) begin bad++; $display("FAIL rot_gap%0d got=%0h exp=%0h", i, obs, exp); end
      end
      we_b = '0;
      $display("txn B rotation writes 0..3");
   endtask

   task automatic test_read_lat3();
      cmd_b = 4'b0101; we_b = '0; addr_b = {8'h00, 8'h01, 8'h00, 8'h02};
      tick();
      obs = 128'({ready_b, cem_b, wem_b, addrm_b, datai_b});
      exp = 128'({4'b0001, 1'b1, 1'b0, 8'h02, 8'h00});
      total++; if (obs !== exp) begin bad++; $display("FAIL rd3_issue0 got=%0h exp=%0h", obs, exp); end
      cmd_b = 4'b0100;
      tick(); tick(); tick();
      obs = 128'(rvalid_b); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL rd3_early got=%0h exp=%0h", obs, exp); end
      tick();
      obs = 128'({rvalid_b, rdata_b}); exp = 128'({4'b0001, 8'hC2});
      total++; if (obs !== exp) begin bad++; $display("FAIL rd3_resp0 got=%0h exp=%0h", obs, exp); end
      tick();
      obs = 128'({ready_b, rvalid_b}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL rd3_idle got=%0h exp=%0h", obs, exp); end
      tick();
      obs = 128'({ready_b, cem_b, wem_b, addrm_b}); exp = 128'({4'b0100, 1'b1, 1'b0, 8'h01});
      total++; if (obs !== exp) begin bad++; $display("FAIL rd3_issue2 got=%0h exp=%0h", obs, exp); end
      cmd_b = '0;
      tick(); tick(); tick(); tick();
      obs = 128'({rvalid_b, rdata_b}); exp = 128'({4'b0100, 8'hC1});
      total++; if (obs !== exp) begin bad++; $display("FAIL rd3_resp2 got=%0h exp=%0h", obs, exp); end
      tick();
      $display("txn B reads ch0 0x02, ch2 0x01 lat3");
   endtask

   task automatic test_reset_rwait();
      int seen;
      cmd_b = 4'b0010; we_b = '0; addr_b = {8'h00, 8'h00, 8'h03, 8'h00};
      tick();
      obs = 128'({ready_b, cem_b}); exp = 128'({4'b0010, 1'b1});
      total++; if (obs !== exp) begin bad++; $display("FAIL rst_rd_issue got=%0h exp=%0h", obs, exp); end
      cmd_b = '0;
      tick();
      tick();
      rst_b = 1'b1;
      #1;
      obs = 128'({ready_b, rvalid_b, rdata_b, wem_b, cem_b, addrm_b, datai_b}); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL rst_async_clear got=%0h exp=%0h", obs, exp); end
      tick();
      rst_b = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (rvalid_b !== 4'b0000) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL rst_no_rvalid got=%0d exp=0", seen); end
      cmd_b = 4'b1001; we_b = 4'b1001;
      addr_b = {8'h30, 8'h00, 8'h00, 8'h20}; wdata_b = {8'h88, 8'h00, 8'h00, 8'h77};
      tick();
      obs = 128'({ready_b, cem_b, wem_b, addrm_b, datai_b});
      exp = 128'({4'b0001, 1'b1, 1'b1, 8'h20, 8'h77});
      total++; if (obs !== exp) begin bad++; $display("FAIL rst_first_grant got=%0h exp=%0h", obs, exp); end
      cmd_b = 4'b1000;
      tick();
      tick();
      obs = 128'({ready_b, cem_b, wem_b, addrm_b, datai_b});
      exp = 128'({4'b1000, 1'b1, 1'b1, 8'h30, 8'h88});
      total++; if (obs !== exp) begin bad++; $display("FAIL rst_second_grant got=%0h exp=%0h", obs, exp); end
      cmd_b = '0; we_b = '0;
      tick();
      $display("txn B reset during read wait");
   endtask

   task automatic test_wide();
      cmd_c = 2'b10; we_c = 2'b10; addr_c = {10'h3FF, 10'h001}; wdata_c = {32'hDEADBEEF, 32'h01234567};
      tick();
      obs = 128'({ready_c, cem_c, wem_c, addrm_c, datai_c});
      exp = 128'({2'b10, 1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF});
      total++; if (obs !== exp) begin bad++; $display("FAIL wide_wr got=%0h exp=%0h", obs, exp); end
      cmd_c = '0; we_c = '0;
      tick();
      cmd_c = 2'b10;
      tick();
      obs = 128'({ready_c, cem_c, wem_c, addrm_c, datai_c});
      exp = 128'({2'b10, 1'b1, 1'b0, 10'h3FF, 32'h0});
      total++; if (obs !== exp) begin bad++; $display("FAIL wide_rd_issue got=%0h exp=%0h", obs, exp); end
      cmd_c = '0;
      tick();
      tick();
      obs = 128'(rvalid_c); exp = '0;
      total++; if (obs !== exp) begin bad++; $display("FAIL wide_early got=%0h exp=%0h", obs, exp); end
      tick();
      obs = 128'({rvalid_c, rdata_c}); exp = 128'({2'b10, 32'hDEADBEEF});
      total++; if (obs !== exp) begin bad++; $display("FAIL wide_resp got=%0h exp=%0h", obs, exp); end
      tick();
      $display("txn C ch1 write/read 0x3ff");
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_write();
      test_read_lat1();
      test_back_to_back();
      test_drop();
      test_single_repeat();
      test_rotation();
      test_read_lat3();
      test_reset_rwait();
      test_wide();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
